i2c_reg_slave: RTL

I2C_REG_SLAVE -- requirements
Module: i2c_reg_slave

---
 rtl/i2c_reg_slave.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_reg_slave.sv
// i2c_reg_slave: I2C slave giving access to 16-bit registers through an 8-bit
// auto-incrementing register pointer (write: dev, reg, hi, lo...; read: dev+R, hi, lo...).
module i2c_reg_slave #(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h5D,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic [7:0]  reg_addr,
    output logic [15:0] reg_wdata,
    output logic        reg_wr_en,
    input  logic [15:0] reg_rdata,
    output logic        busy
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [3:0] {
        IDLE, DEV_ADDR, ACK_DEV, REG_ADDR, ACK_REG, WR_HI, ACK_HI, WR_LO, ACK_LO,
        RD_HI, MACK_HI, RD_LO, MACK_LO, WAIT_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [7:0]             rx_q, rx_d, data_hi_q, data_hi_d;
    logic [15:0]            tx_q, tx_d;
    logic                   mack_q, mack_d;      // 1 = master NACK
    logic                   reload_q, reload_d;  // refill tx after pointer bump
    logic                   sda_oe_q, sda_oe_d;
    logic [7:0]             reg_addr_q, reg_addr_d;
    logic [15:0]            reg_wdata_q, reg_wdata_d;
    logic                   reg_wr_en_q, reg_wr_en_d;
    logic                   busy_q, busy_d;

    logic scl_s, sda_s, scl_rise_c, scl_fall_c, start_c, stop_c;

    // Synchronized bus lines and bus condition detection
    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise_c = scl_s & ~scl_prev_q;
    assign scl_fall_c = ~scl_s & scl_prev_q;
    assign start_c    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_c     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        scl_sync_d  = SYNC_STAGES'({scl_sync_q, scl_in});
        sda_sync_d  = SYNC_STAGES'({sda_sync_q, sda_in});
        scl_prev_d  = scl_s;
        sda_prev_d  = sda_s;
        cnt_d       = cnt_q;
        rx_d        = rx_q;
        data_hi_d   = data_hi_q;
        tx_d        = tx_q;
        mack_d      = mack_q;
        reload_d    = 1'b0;
        sda_oe_d    = sda_oe_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_wr_en_d = 1'b0;

        if (reg_wr_en_q) reg_addr_d = reg_addr_q + 8'd1;

        if (reload_q) begin
            tx_d     = reg_rdata;
            sda_oe_d = ~reg_rdata[15];
        end

        if (start_c) begin
            state_d  = DEV_ADDR;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            reload_d = 1'b0;
        end else if (stop_c) begin
            state_d  = IDLE;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            reload_d = 1'b0;
        end else begin
            case (state_q)
                DEV_ADDR, REG_ADDR, WR_HI, WR_LO: begin
                    if (scl_rise_c) begin
                        rx_d  = {rx_q[6:0], sda_s};
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(7)) begin
                            if (state_q == REG_ADDR) reg_addr_d = {rx_q[6:0], sda_s};
                            if (state_q == WR_LO) begin
                                reg_wdata_d = {data_hi_q, rx_q[6:0], sda_s};
                                reg_wr_en_d = 1'b1;
                            end
                        end
                    end else if (scl_fall_c && cnt_q == CNT_W'(8)) begin
                        cnt_d = '0;
                        if (state_q == DEV_ADDR) begin
                            if (rx_q[7:1] == SLAVE_ADDR) begin
                                state_d  = ACK_DEV;
                                sda_oe_d = 1'b1;
                            end else begin
                                state_d  = WAIT_STOP;
                            end
                        end else if (state_q == REG_ADDR) begin
                            state_d  = ACK_REG;
                            sda_oe_d = 1'b1;
                        end else if (state_q == WR_HI) begin
                            data_hi_d = rx_q;
                            state_d   = ACK_HI;
                            sda_oe_d  = 1'b1;
                        end else begin
                            state_d  = ACK_LO;
                            sda_oe_d = 1'b1;
                        end
                    end
                end
                ACK_DEV, ACK_REG, ACK_HI, ACK_LO: begin
                    if (scl_fall_c) begin
                        sda_oe_d = 1'b0;
                        cnt_d    = '0;
                        if (state_q == ACK_DEV) begin
                            if (rx_q[0]) begin
                                state_d  = RD_HI;
                                tx_d     = reg_rdata;
                                sda_oe_d = ~reg_rdata[15];
                            end else begin
                                state_d  = REG_ADDR;
                            end
                        end else if (state_q == ACK_HI) begin
                            state_d = WR_LO;
                        end else begin
                            state_d = WR_HI;
                        end
                    end
                end
                RD_HI, RD_LO: begin
                    if (scl_rise_c) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (scl_fall_c) begin
                        if (cnt_q == CNT_W'(8)) begin
                            cnt_d    = '0;
                            sda_oe_d = 1'b0;
                            state_d  = (state_q == RD_HI) ? MACK_HI : MACK_LO;
                        end else begin
                            tx_d     = tx_q << 1;
                            sda_oe_d = ~tx_d[15];
                        end
                    end
                end
                MACK_HI, MACK_LO: begin
                    if (scl_rise_c) begin
                        mack_d = sda_s;
                    end else if (scl_fall_c) begin
                        cnt_d = '0;
                        if (mack_q) begin
                            state_d  = WAIT_STOP;
                            sda_oe_d = 1'b0;
                        end else if (state_q == MACK_HI) begin
                            state_d  = RD_LO;
                            tx_d     = tx_q << 1;
                            sda_oe_d = ~tx_d[15];
                        end else begin
                            state_d    = RD_HI;
                            reg_addr_d = reg_addr_q + 8'd1;
                            reload_d   = 1'b1;
                        end
                    end
                end
                default: begin
                    sda_oe_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != IDLE) && (state_d != WAIT_STOP);
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            cnt_q       <= '0;
            rx_q        <= '0;
            data_hi_q   <= '0;
            tx_q        <= '0;
            mack_q      <= 1'b0;
            reload_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_wr_en_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            scl_prev_q  <= scl_prev_d;
            sda_prev_q  <= sda_prev_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            data_hi_q   <= data_hi_d;
            tx_q        <= tx_d;
            mack_q      <= mack_d;
            reload_q    <= reload_d;
            sda_oe_q    <= sda_oe_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_wr_en_q <= reg_wr_en_d;
            busy_q      <= busy_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_wr_en = reg_wr_en_q;
    assign busy      = busy_q;

endmodule
